// File: rtl/uart_rx_sniffer.sv
// UART receive sniffer: recovers bytes from an idle-high serial pin.
// Build option: define UART_RX_SNIFF_PARITY_EN for 8E1 frames with a live parity_err.
module uart_rx_sniffer #(
  parameter int unsigned CLK_DIV = 104,
  parameter string       TYPE    = "generic"
) (
  input  logic       theclk,
  input  logic       theresetn,
  input  logic       rxd,
  output logic [7:0] uart_data,
  output logic       uart_data_valid,
  output logic       framing_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2 - 1);

`ifdef UART_RX_SNIFF_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop, StBrk} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBrk} state_e;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bitn_q, bitn_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_d;
  logic            valid_d, ferr_d;
  logic            rx_meta_q, rxs;
`ifdef UART_RX_SNIFF_PARITY_EN
  logic            par_q, par_d;
  logic            perr_q, perr_d;
`endif

  // Two-flop synchronizer; resets to the idle level so no false start after reset.
  always_ff @(posedge theclk or negedge theresetn) begin
    if (!theresetn) begin
      rx_meta_q <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rxs       <= rx_meta_q;
    end
  end

  always_ff @(posedge theclk or negedge theresetn) begin
    if (!theresetn) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      bitn_q          <= '0;
      shift_q         <= '0;
      uart_data       <= '0;
      uart_data_valid <= 1'b0;
      framing_err     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bitn_q          <= bitn_d;
      shift_q         <= shift_d;
      uart_data       <= data_d;
      uart_data_valid <= valid_d;
      framing_err     <= ferr_d;
      busy            <= (state_d != StIdle);
    end
  end

`ifdef UART_RX_SNIFF_PARITY_EN
  always_ff @(posedge theclk or negedge theresetn) begin
    if (!theresetn) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    bitn_d  = bitn_q;
    shift_d = shift_q;
    data_d  = uart_data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_SNIFF_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxs) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          bitn_d  = '0;
          // A line back high at mid-start-bit is a glitch, not a frame.
          state_d = rxs ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d           = '0;
          shift_d[bitn_q] = rxs;
          bitn_d          = bitn_q + 3'd1;
          if (bitn_q == 3'd7) begin
`ifdef UART_RX_SNIFF_PARITY_EN
            state_d = StPar;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_SNIFF_PARITY_EN
      StPar: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          par_d   = rxs;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rxs) begin
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_SNIFF_PARITY_EN
            perr_d  = ^{shift_q, par_q};
`endif
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBrk;
          end
        end
      end
      StBrk: begin
        cnt_d = '0;
        if (rxs) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_sniffer.sv
// Scoreboard bench for uart_rx_sniffer at CLK_DIV=8: stimulus pushes expected events,
// a negedge monitor pops and compares whenever a valid/error strobe appears.
module tb_uart_rx_sniffer;

  localparam int Div = 8;
`ifdef UART_RX_SNIFF_PARITY_EN
  localparam int NBits = 10;
`else
  localparam int NBits = 9;
`endif
  // Pin edge to strobe: 2 sync + 1 IDLE + HALF + NBits*Div.
  localparam int Lat = 3 + Div / 2 + NBits * Div;

  logic       theclk = 1'b0;
  logic       theresetn = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] uart_data;
  logic       uart_data_valid, framing_err, parity_err, busy;

  typedef struct {
    logic       v;
    logic       f;
    logic       p;
    logic [7:0] d;
    int         c;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] last_good = 8'h00;
  bit         busy_seen;

  uart_rx_sniffer #(.CLK_DIV(Div), .TYPE("generic")) dut (
    .theclk         (theclk),
    .theresetn      (theresetn),
    .rxd            (rxd),
    .uart_data      (uart_data),
    .uart_data_valid(uart_data_valid),
    .framing_err    (framing_err),
    .parity_err     (parity_err),
    .busy           (busy)
  );

  always #5 theclk = ~theclk;
  always @(posedge theclk) cyc++;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge theclk) begin
    if (theresetn && (uart_data_valid || framing_err || parity_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: valid=%0b ferr=%0b perr=%0b data=0x%0h, expected none",
                 uart_data_valid, framing_err, parity_err, uart_data);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("valid", int'(uart_data_valid), int'(e.v));
        check("framing_err", int'(framing_err), int'(e.f));
        check("parity_err", int'(parity_err), int'(e.p));
        check("uart_data", int'(uart_data), int'(e.d));
        check("strobe_cycle", cyc, e.c);
      end
    end
    if (busy) busy_seen = 1'b1;
  end

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (Div) @(posedge theclk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge theclk);
    #1;
  endtask

  // stop: stop-bit level; flip: send wrong parity (parity build only).
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
    ev_t e;
    e.v = stop;
    e.f = !stop;
`ifdef UART_RX_SNIFF_PARITY_EN
    e.p = stop && flip;
`else
    e.p = 1'b0;
`endif
    if (stop) last_good = d;
    e.d = last_good;
    e.c = cyc + Lat;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_SNIFF_PARITY_EN
    drive_bit((^d) ^ flip);
`endif
    drive_bit(stop);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge theclk);
    @(negedge theclk);
    check("rst_uart_data", int'(uart_data), 0);
    check("rst_valid", int'(uart_data_valid), 0);
    check("rst_framing_err", int'(framing_err), 0);
    check("rst_parity_err", int'(parity_err), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge theclk);
    #1 theresetn = 1'b1;
    idle(5);

    // Good bytes
    send_frame(8'h55, 1'b1, 1'b0);
    idle(10);
    send_frame(8'h0A, 1'b1, 1'b0);
    idle(10);

    // Glitch: two low cycles must not produce any strobe
    busy_seen = 1'b0;
    rxd = 1'b0;
    repeat (2) @(posedge theclk);
    #1;
    idle(20);
    check("glitch_busy_seen", int'(busy_seen), 1);
    check("glitch_busy_back_idle", int'(busy), 0);
    check("glitch_data_held", int'(uart_data), 8'h0A);

    // Framing error then break held low
    send_frame(8'hA3, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (40) @(posedge theclk);
    #1;
    idle(12);
    check("break_data_held", int'(uart_data), 8'h0A);
    send_frame(8'h41, 1'b1, 1'b0);
    idle(10);

    // Back-to-back frames
    send_frame(8'h48, 1'b1, 1'b0);
    send_frame(8'h69, 1'b1, 1'b0);
    send_frame(8'h0D, 1'b1, 1'b0);
    idle(10);

    // Reset during bit 3 of 0xFF
    drive_bit(1'b0);
    rxd = 1'b1;
    repeat (3 * Div + Div / 2) @(posedge theclk);
    #1 theresetn = 1'b0;
    @(negedge theclk);
    check("midrst_uart_data", int'(uart_data), 0);
    check("midrst_valid", int'(uart_data_valid), 0);
    check("midrst_framing_err", int'(framing_err), 0);
    check("midrst_busy", int'(busy), 0);
    last_good = 8'h00;
    repeat (3) @(posedge theclk);
    #1 theresetn = 1'b1;
    idle(6 * Div);
    check("postrst_busy", int'(busy), 0);
    send_frame(8'h31, 1'b1, 1'b0);
    idle(10);

`ifdef UART_RX_SNIFF_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b0);
    idle(10);
    // 0x07 has odd weight, so a 0 parity bit is a mismatch
    send_frame(8'h07, 1'b1, 1'b1);
    idle(10);
`endif

    idle(20);
    check("all_events_seen", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
